// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: synchronous-read word array with big/little-endian byte lanes, optional wait states,
// two-cycle ERROR on illegal size/alignment, and write-to-read forwarding for back-to-back accesses.
module ahb_sram_slave #(
    parameter int MEM_AWDT       = 12,
    parameter int WAIT_STATES    = 0,
    parameter bit BIG_ENDIAN_AHB = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
);
    localparam int         DEPTH   = 1 << MEM_AWDT;
    localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t              state, state_nxt;
    logic [2:0]          cnt, cnt_nxt;
    logic [MEM_AWDT-1:0] idx_q, idx_a, rd_idx;
    logic                write_q;
    logic [3:0]          be_q, be_a, ofs_mask;
    logic                slot_free, accept, legal, we;
    logic [31:0]         bitmask, rd_raw, rd_fwd, rdata_q;
    logic [31:0]         mem [DEPTH];
    logic                unused;

    assign unused = ^{HBURST, HPROT, HTRANS[0], HADDR[31:MEM_AWDT+2]};

    // A new address phase can only be taken while this slave is not stalling the bus.
    assign slot_free = (state != ST_WAIT) && (state != ST_ERR1);
    assign accept    = HSEL && HREADY && HTRANS[1] && slot_free;
    assign idx_a     = HADDR[MEM_AWDT+1:2];

    always_comb begin
        legal = 1'b0;
        case (HSIZE)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~HADDR[0];
            3'b010:  legal = (HADDR[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Byte mask in offset order first, then mapped onto bus lanes.
    always_comb begin
        ofs_mask = 4'b1111;
        case (HSIZE[1:0])
            2'b00:   ofs_mask = 4'b0001 << HADDR[1:0];
            2'b01:   ofs_mask = 4'b0011 << HADDR[1:0];
            default: ofs_mask = 4'b1111;
        endcase
        be_a = 4'b0000;
        for (int i = 0; i < 4; i++)
            be_a[i] = BIG_ENDIAN_AHB ? ofs_mask[3-i] : ofs_mask[i];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt == 3'd0) state_nxt = ST_DATA;
                else             cnt_nxt   = cnt - 3'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: ;
        endcase
        if (slot_free) begin
            if (!accept)               state_nxt = ST_IDLE;
            else if (!legal)           state_nxt = ST_ERR1;
            else if (WAIT_STATES > 0) begin
                state_nxt = ST_WAIT;
                cnt_nxt   = WS_LOAD;
            end else                   state_nxt = ST_DATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            cnt     <= 3'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            be_q    <= 4'b0000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                idx_q   <= idx_a;
                write_q <= HWRITE && legal;
                be_q    <= be_a;
            end
        end
    end

    assign HREADYOUT = slot_free;
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

    // Writes land only in the completing cycle, so an aborted data phase never touches the array.
    assign we = (state == ST_DATA) && write_q;

    always_comb begin
        bitmask = '0;
        for (int i = 0; i < 4; i++)
            bitmask[8*i +: 8] = {8{we && be_q[i]}};
    end

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 4; i++)
            if (we && be_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
    end

    assign rd_idx = accept ? idx_a : idx_q;
    assign rd_raw = mem[rd_idx];
    assign rd_fwd = (rd_idx == idx_q) ? ((rd_raw & ~bitmask) | (HWDATA & bitmask)) : rd_raw;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) rdata_q <= 32'd0;
        else          rdata_q <= rd_fwd;
    end

    assign HRDATA = rdata_q;
endmodule
